// File: rtl/flappy_pkg.sv
// Shared game-state encoding, default timing constants and counter sizing
// for the Flappy VGA game controller.
package flappy_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READY = 2'd1,
      ST_PLAY  = 2'd2,
      ST_OVER  = 2'd3
   } game_state_e;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEF_READY_CYCLES    = 50000000;
   localparam int unsigned DEF_SCROLL_DIV      = 524288;
   localparam int unsigned DEF_PHYS_DIV        = 1048576;
   localparam int unsigned DEF_FLASH_DIV       = 2097152;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: two-flop synchronizer, stability counter and
// rising-edge press detect on the accepted (stable) level.
module btn_debounce
   import flappy_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic board_clk,
   input  logic Reset,
   input  logic btn_raw_i,
   output logic press_o
);

   localparam int unsigned   CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic          stable_prev_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         sync1_q       <= btn_raw_i;
         sync2_q       <= sync1_q;
         stable_prev_q <= stable_q;
         // Count only while the synced level disagrees with the accepted one.
         if (sync2_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign press_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/game_sequencer.sv
// Flappy VGA game controller: debounced buttons, IDLE/READY/PLAY/OVER state
// machine, one-cycle control pulses, scroll/physics enables, flash and high score.
module game_sequencer
   import flappy_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned READY_CYCLES    = DEF_READY_CYCLES,
   parameter int unsigned SCROLL_DIV      = DEF_SCROLL_DIV,
   parameter int unsigned PHYS_DIV        = DEF_PHYS_DIV,
   parameter int unsigned FLASH_DIV       = DEF_FLASH_DIV
) (
   input  logic       board_clk,
   input  logic       Reset,
   input  logic       btn_start,
   input  logic       btn_jump,
   input  logic       lose_in,
   input  logic [3:0] score_in,
   output logic       start_pulse,
   output logic       ack_pulse,
   output logic       jump_pulse,
   output logic       scroll_tick,
   output logic       phys_tick,
   output logic       flash,
   output logic [3:0] high_score,
   output logic [1:0] state
);

   localparam int unsigned RW = cnt_width(READY_CYCLES);
   localparam int unsigned SW = cnt_width(SCROLL_DIV);
   localparam int unsigned PW = cnt_width(PHYS_DIV);
   localparam int unsigned FW = cnt_width(FLASH_DIV);

   localparam logic [RW-1:0] READY_MAX  = RW'(READY_CYCLES - 1);
   localparam logic [SW-1:0] SCROLL_MAX = SW'(SCROLL_DIV - 1);
   localparam logic [PW-1:0] PHYS_MAX   = PW'(PHYS_DIV - 1);
   localparam logic [FW-1:0] FLASH_MAX  = FW'(FLASH_DIV - 1);

   logic start_press;
   logic jump_press;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .board_clk (board_clk),
      .Reset     (Reset),
      .btn_raw_i (btn_start),
      .press_o   (start_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_jump (
      .board_clk (board_clk),
      .Reset     (Reset),
      .btn_raw_i (btn_jump),
      .press_o   (jump_press)
   );

   game_state_e   state_q;
   logic [RW-1:0] ready_cnt_q;
   logic [SW-1:0] scroll_cnt_q;
   logic [PW-1:0] phys_cnt_q;
   logic [FW-1:0] flash_cnt_q;
   logic          start_pulse_q;
   logic          ack_pulse_q;
   logic          jump_pulse_q;
   logic          scroll_tick_q;
   logic          phys_tick_q;
   logic          flash_q;
   logic [3:0]    high_score_q;

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         ready_cnt_q   <= '0;
         scroll_cnt_q  <= '0;
         phys_cnt_q    <= '0;
         flash_cnt_q   <= '0;
         start_pulse_q <= 1'b0;
         ack_pulse_q   <= 1'b0;
         jump_pulse_q  <= 1'b0;
         scroll_tick_q <= 1'b0;
         phys_tick_q   <= 1'b0;
         flash_q       <= 1'b0;
         high_score_q  <= '0;
      end else begin
         start_pulse_q <= 1'b0;
         ack_pulse_q   <= 1'b0;
         jump_pulse_q  <= 1'b0;
         scroll_tick_q <= 1'b0;
         phys_tick_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_press) begin
                  state_q     <= ST_READY;
                  ready_cnt_q <= '0;
               end
            end
            ST_READY: begin
               if (ready_cnt_q == READY_MAX) begin
                  state_q       <= ST_PLAY;
                  start_pulse_q <= 1'b1;
                  scroll_cnt_q  <= '0;
                  phys_cnt_q    <= '0;
               end else begin
                  ready_cnt_q <= ready_cnt_q + RW'(1);
               end
            end
            ST_PLAY: begin
               // Ticks still fire on the losing cycle; OVER emits none.
               if (scroll_cnt_q == SCROLL_MAX) begin
                  scroll_cnt_q  <= '0;
                  scroll_tick_q <= 1'b1;
               end else begin
                  scroll_cnt_q <= scroll_cnt_q + SW'(1);
               end
               if (phys_cnt_q == PHYS_MAX) begin
                  phys_cnt_q  <= '0;
                  phys_tick_q <= 1'b1;
               end else begin
                  phys_cnt_q <= phys_cnt_q + PW'(1);
               end
               jump_pulse_q <= jump_press & ~lose_in;
               if (lose_in) begin
                  state_q     <= ST_OVER;
                  flash_cnt_q <= '0;
                  flash_q     <= 1'b0;
                  if (score_in > high_score_q) high_score_q <= score_in;
               end
            end
            ST_OVER: begin
               if (start_press) begin
                  state_q     <= ST_IDLE;
                  ack_pulse_q <= 1'b1;
                  flash_q     <= 1'b0;
                  flash_cnt_q <= '0;
               end else if (flash_cnt_q == FLASH_MAX) begin
                  flash_cnt_q <= '0;
                  flash_q     <= ~flash_q;
               end else begin
                  flash_cnt_q <= flash_cnt_q + FW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign start_pulse = start_pulse_q;
   assign ack_pulse   = ack_pulse_q;
   assign jump_pulse  = jump_pulse_q;
   assign scroll_tick = scroll_tick_q;
   assign phys_tick   = phys_tick_q;
   assign flash       = flash_q;
   assign high_score  = high_score_q;
   assign state       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues hand-timed pulse events,
// a negedge monitor pops and compares whenever any pulse/tick is high.
module tb_game_sequencer;

   localparam int unsigned DB = 4;
   localparam int unsigned RC = 20;
   localparam int unsigned SD = 8;
   localparam int unsigned PD = 16;
   localparam int unsigned FD = 10;

   localparam logic [4:0] P_START = 5'b10000;
   localparam logic [4:0] P_ACK   = 5'b01000;
   localparam logic [4:0] P_JUMP  = 5'b00100;
   localparam logic [4:0] P_SCR   = 5'b00010;
   localparam logic [4:0] P_PHY   = 5'b00001;

   logic       board_clk = 1'b0;
   logic       Reset     = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_jump  = 1'b0;
   logic       lose_in   = 1'b0;
   logic [3:0] score_in  = 4'd0;
   logic       start_pulse, ack_pulse, jump_pulse, scroll_tick, phys_tick, flash;
   logic [3:0] high_score;
   logic [1:0] state;

   int cyc   = 0;
   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int         cyc;
      logic [4:0] pulses;
      logic [1:0] st;
      logic [3:0] hs;
      logic       fl;
   } exp_t;

   exp_t exp_q[$];

   game_sequencer #(
      .DEBOUNCE_CYCLES (DB),
      .READY_CYCLES    (RC),
      .SCROLL_DIV      (SD),
      .PHYS_DIV        (PD),
      .FLASH_DIV       (FD)
   ) dut (
      .board_clk   (board_clk),
      .Reset       (Reset),
      .btn_start   (btn_start),
      .btn_jump    (btn_jump),
      .lose_in     (lose_in),
      .score_in    (score_in),
      .start_pulse (start_pulse),
      .ack_pulse   (ack_pulse),
      .jump_pulse  (jump_pulse),
      .scroll_tick (scroll_tick),
      .phys_tick   (phys_tick),
      .flash       (flash),
      .high_score  (high_score),
      .state       (state)
   );

   always #5 board_clk = ~board_clk;
   always @(posedge board_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int req);
      n_cmp++;
      if (got != req) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d (cyc %0d)", name, got, req, cyc);
      end
   endtask

   task automatic push(input int c, input logic [4:0] p, input logic [1:0] s, input logic [3:0] h);
      exp_t e;
      e.cyc = c; e.pulses = p; e.st = s; e.hs = h; e.fl = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge board_clk);
   endtask

   always @(negedge board_clk) begin : monitor
      logic [4:0] obs;
      exp_t       e;
      obs = {start_pulse, ack_pulse, jump_pulse, scroll_tick, phys_tick};
      if (obs != 5'b0) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pulse: got pulses=%b at cyc %0d required none", obs, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.pulses != obs || e.st != state || e.hs != high_score || e.fl != flash) begin
               n_err++;
               $display("FAIL event: got cyc=%0d pulses=%b state=%0d hs=%0d flash=%b required cyc=%0d pulses=%b state=%0d hs=%0d flash=%b",
                        cyc, obs, state, high_score, flash, e.cyc, e.pulses, e.st, e.hs, e.fl);
            end
         end
      end
   end

   initial begin
      int h, p, l, a0, b0, p2, l2, d0, p3;

      wait_cyc(1);
      check("reset_state", state, 0);
      check("reset_high_score", high_score, 0);
      check("reset_flash", flash, 0);
      check("reset_pulses", {start_pulse, ack_pulse, jump_pulse, scroll_tick, phys_tick}, 0);
      wait_cyc(2);
      Reset = 1'b0;

      // Bounce: toggle every 2 cycles for 20 cycles, then hold high.
      for (int i = 0; i < 10; i++) begin
         wait_cyc(5 + 2 * i);
         btn_start = (i % 2 == 0);
      end
      h = 25;
      wait_cyc(h);
      btn_start = 1'b1;
      p = h + 7 + RC;
      l = p + 40;
      push(p,      P_START,       2'd2, 4'd0);
      push(p + 8,  P_SCR,         2'd2, 4'd0);
      push(p + 9,  P_JUMP,        2'd2, 4'd0);
      push(p + 16, P_SCR | P_PHY, 2'd2, 4'd0);
      push(p + 24, P_SCR,         2'd2, 4'd0);
      push(p + 32, P_SCR | P_PHY, 2'd2, 4'd0);
      push(l,      P_SCR,         2'd3, 4'd5);
      wait_cyc(h + 6);
      check("bounce_still_idle", state, 0);
      wait_cyc(h + 7);
      check("ready_after_debounce", state, 1);

      // Jump in READY must be ignored.
      wait_cyc(h + 8);
      btn_start = 1'b0;
      btn_jump  = 1'b1;
      wait_cyc(h + 18);
      btn_jump = 1'b0;
      wait_cyc(p - 1);
      check("ready_last_cycle", state, 1);

      // Jump in PLAY gives one jump_pulse.
      wait_cyc(p + 2);
      btn_jump = 1'b1;
      wait_cyc(p + 10);
      btn_jump = 1'b0;

      // Jump press landing on the lose cycle, which is also a scroll wrap.
      wait_cyc(l - 7);
      btn_jump = 1'b1;
      wait_cyc(l - 1);
      lose_in  = 1'b1;
      score_in = 4'd5;
      wait_cyc(l);
      lose_in = 1'b0;
      check("over_state", state, 3);
      check("high_score_5", high_score, 5);
      wait_cyc(l + 9);
      btn_jump = 1'b0;
      check("flash_before_first_toggle", flash, 0);
      wait_cyc(l + 10);
      check("flash_first_toggle", flash, 1);
      wait_cyc(l + 20);
      check("flash_second_toggle", flash, 0);

      // Ack back to IDLE.
      a0 = l + 22;
      wait_cyc(a0);
      btn_start = 1'b1;
      push(a0 + 7, P_ACK, 2'd0, 4'd5);
      wait_cyc(a0 + 10);
      btn_start = 1'b0;

      // Replay with a lower score.
      b0 = a0 + 20;
      wait_cyc(b0);
      btn_start = 1'b1;
      p2 = b0 + 7 + RC;
      l2 = p2 + 20;
      push(p2,      P_START,       2'd2, 4'd5);
      push(p2 + 8,  P_SCR,         2'd2, 4'd5);
      push(p2 + 16, P_SCR | P_PHY, 2'd2, 4'd5);
      wait_cyc(b0 + 10);
      btn_start = 1'b0;
      wait_cyc(l2 - 1);
      lose_in  = 1'b1;
      score_in = 4'd3;
      wait_cyc(l2);
      lose_in = 1'b0;
      check("replay_over_state", state, 3);
      check("high_score_kept", high_score, 5);

      // Ack while flash is high: flash must drop on exit.
      wait_cyc(l2 + 5);
      btn_start = 1'b1;
      push(l2 + 12, P_ACK, 2'd0, 4'd5);
      wait_cyc(l2 + 11);
      check("flash_high_before_ack", flash, 1);
      wait_cyc(l2 + 15);
      btn_start = 1'b0;

      // Third game, aborted by async reset right after a scroll tick.
      d0 = l2 + 30;
      wait_cyc(d0);
      btn_start = 1'b1;
      p3 = d0 + 7 + RC;
      push(p3,     P_START, 2'd2, 4'd5);
      push(p3 + 8, P_SCR,   2'd2, 4'd5);
      wait_cyc(d0 + 10);
      btn_start = 1'b0;
      wait_cyc(p3 + 8);
      check("mid_play_state", state, 2);
      #2 Reset = 1'b1;
      #1;
      check("async_reset_state", state, 0);
      check("async_reset_high_score", high_score, 0);
      check("async_reset_scroll_tick", scroll_tick, 0);
      check("async_reset_flash", flash, 0);
      wait_cyc(p3 + 12);
      Reset = 1'b0;

      wait_cyc(p3 + 40);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
